// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the programmable up/down counter.
// The direction and mode encodings are used by both the top level and the next-state logic.
package updown_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Limits an input such as a step or load value to the terminal count.
   function automatic logic [31:0] clampToMax(input logic [31:0] value, input logic [31:0] maxVal);
      return (value > maxVal) ? maxVal : value;
   endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count calculation with wrap/saturate handling and event detection.
// The arithmetic is one bit wider than the count, so no intermediate result wraps at 2**WIDTH.
module updown_counter_next
   import updown_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic [WIDTH-1:0] i_step,
   input  logic             i_upDown,
   input  logic             i_satMode,
   output logic [WIDTH-1:0] o_nextCount,
   output logic             o_ovfNext,
   output logic             o_unfNext
);

   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] MODULUS = MAX_EXT + (WIDTH+1)'(1);

   logic [WIDTH:0] w_countExt;
   logic [WIDTH:0] w_stepExt;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_result;

   assign w_countExt = {1'b0, i_count};
   assign w_stepExt  = {1'b0, i_step};
   assign w_sum      = w_countExt + w_stepExt;

   // A zero step never crosses a boundary in either direction, so it holds without flags.
   always_comb begin
      w_result  = w_countExt;
      o_ovfNext = 1'b0;
      o_unfNext = 1'b0;
      if (i_upDown == DIR_UP) begin
         if (w_sum > MAX_EXT) begin
            o_ovfNext = 1'b1;
            w_result  = (i_satMode == MODE_SAT) ? MAX_EXT : (w_sum - MODULUS);
         end else begin
            w_result = w_sum;
         end
      end else begin
         if (w_stepExt > w_countExt) begin
            o_unfNext = 1'b1;
            w_result  = (i_satMode == MODE_SAT) ? '0 : (w_countExt + MODULUS - w_stepExt);
         end else begin
            w_result = w_countExt - w_stepExt;
         end
      end
   end

   assign o_nextCount = WIDTH'(w_result);

endmodule

// File: rtl/updown_counter_mod.sv
// Programmable-modulus up/down counter with variable step, parallel load and wrap/saturate modes.
// Count and over/underflow pulses are registered; the at_max/at_min flags are decoded from the count.
module updown_counter_mod
   import updown_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_VAL   = 2**WIDTH-1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic [WIDTH-1:0] step,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_min
);

   if (WIDTH < 2 || MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1) ||
       RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_paramCheck
      $error("updown_counter_mod: illegal WIDTH/MAX_VAL/RESET_VAL combination");
   end

   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;
   logic [WIDTH-1:0] w_stepClamped;
   logic [WIDTH-1:0] w_loadClamped;
   logic [WIDTH-1:0] w_nextCount;
   logic             w_ovfNext;
   logic             w_unfNext;

   assign w_stepClamped = WIDTH'(clampToMax(32'(step), 32'(MAX_VAL)));
   assign w_loadClamped = WIDTH'(clampToMax(32'(load_val), 32'(MAX_VAL)));

   updown_counter_next #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) u_next (
      .i_count     (r_count),
      .i_step      (w_stepClamped),
      .i_upDown    (up_down),
      .i_satMode   (sat_mode),
      .o_nextCount (w_nextCount),
      .o_ovfNext   (w_ovfNext),
      .o_unfNext   (w_unfNext)
   );

   // Load wins over counting; the event pulses are cleared on any cycle that is not a counting step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= RESET_W;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (load) begin
         r_count <= w_loadClamped;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (en) begin
         r_count <= w_nextCount;
         r_ovf   <= w_ovfNext;
         r_unf   <= w_unfNext;
      end else begin
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end
   end

   assign count  = r_count;
   assign ovf    = r_ovf;
   assign unf    = r_unf;
   assign at_max = (r_count == MAX_W);
   assign at_min = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for the up/down counter: a decade counter instance plus an 8-bit instance.
// Directed stimulus pushes hand-computed expectations; a monitor pops and checks them after each edge.
module tb_updown_counter_mod;

   typedef struct {
      string tag;
      int    cnt;
      bit    ovf;
      bit    unf;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic       upDown;
   logic [3:0] step;
   logic       satMode;
   logic       load;
   logic [3:0] loadVal;
   logic [3:0] count;
   logic       ovf;
   logic       unf;
   logic       atMax;
   logic       atMin;

   logic       resetB;
   logic       enB;
   logic       upDownB;
   logic [7:0] stepB;
   logic       satModeB;
   logic       loadB;
   logic [7:0] loadValB;
   logic [7:0] countB;
   logic       ovfB;
   logic       unfB;
   logic       atMaxB;
   logic       atMinB;

   exp_t qA[$];
   exp_t qB[$];
   int   total = 0;
   int   bad   = 0;

   updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dutA (
      .clk(clk), .reset(reset), .en(en), .up_down(upDown), .step(step),
      .sat_mode(satMode), .load(load), .load_val(loadVal), .count(count),
      .ovf(ovf), .unf(unf), .at_max(atMax), .at_min(atMin)
   );

   updown_counter_mod #(.WIDTH(8), .MAX_VAL(255), .RESET_VAL(250)) dutB (
      .clk(clk), .reset(resetB), .en(enB), .up_down(upDownB), .step(stepB),
      .sat_mode(satModeB), .load(loadB), .load_val(loadValB), .count(countB),
      .ovf(ovfB), .unf(unfB), .at_max(atMaxB), .at_min(atMinB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input int required);
      total++;
      if (actual !== 32'(required)) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input string tag, input bit e, input bit ud, input int s,
                                input bit sat, input bit ld, input int ldv,
                                input int expCnt, input bit expOvf, input bit expUnf);
      exp_t item;
      @(negedge clk);
      en      = e;
      upDown  = ud;
      step    = 4'(s);
      satMode = sat;
      load    = ld;
      loadVal = 4'(ldv);
      item.tag = tag;
      item.cnt = expCnt;
      item.ovf = expOvf;
      item.unf = expUnf;
      qA.push_back(item);
   endtask

   // Monitor: every edge presents a new registered result, checked against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (qA.size() > 0) begin
         e = qA.pop_front();
         checkOutput({e.tag, " count"},  32'(count), e.cnt);
         checkOutput({e.tag, " ovf"},    32'(ovf),   int'(e.ovf));
         checkOutput({e.tag, " unf"},    32'(unf),   int'(e.unf));
         checkOutput({e.tag, " at_max"}, 32'(atMax), (e.cnt == 9) ? 1 : 0);
         checkOutput({e.tag, " at_min"}, 32'(atMin), (e.cnt == 0) ? 1 : 0);
      end
      if (qB.size() > 0) begin
         e = qB.pop_front();
         checkOutput({e.tag, " countB"}, 32'(countB), e.cnt);
         checkOutput({e.tag, " ovfB"},   32'(ovfB),   int'(e.ovf));
         checkOutput({e.tag, " unfB"},   32'(unfB),   int'(e.unf));
      end
   end

   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t itemB;
      reset = 1'b1; en = 1'b0; upDown = 1'b1; step = '0; satMode = 1'b0; load = 1'b0; loadVal = '0;
      resetB = 1'b1; enB = 1'b0; upDownB = 1'b1; stepB = '0; satModeB = 1'b0; loadB = 1'b0; loadValB = '0;

      #12;
      checkOutput("reset count",  32'(count),  0);
      checkOutput("reset ovf",    32'(ovf),    0);
      checkOutput("reset unf",    32'(unf),    0);
      checkOutput("reset at_min", 32'(atMin),  1);
      checkOutput("reset at_max", 32'(atMax),  0);
      checkOutput("reset countB", 32'(countB), 250);
      @(negedge clk);
      reset  = 1'b0;
      resetB = 1'b0;

      applyStimulus("ld8",     0, 1, 0,  0, 1, 8,  8, 0, 0);
      applyStimulus("wrapUp1", 1, 1, 1,  0, 0, 0,  9, 0, 0);
      applyStimulus("wrapUp2", 1, 1, 1,  0, 0, 0,  0, 1, 0);
      applyStimulus("wrapUp3", 1, 1, 1,  0, 0, 0,  1, 0, 0);
      applyStimulus("ld1",     0, 1, 0,  0, 1, 1,  1, 0, 0);
      applyStimulus("wrapDn3", 1, 0, 3,  0, 0, 0,  8, 0, 1);
      applyStimulus("wrapDnC", 1, 0, 12, 0, 0, 0,  9, 0, 1);
      applyStimulus("ld7",     0, 1, 0,  0, 1, 7,  7, 0, 0);
      applyStimulus("satUp1",  1, 1, 4,  1, 0, 0,  9, 1, 0);
      applyStimulus("satUp2",  1, 1, 4,  1, 0, 0,  9, 1, 0);
      applyStimulus("satDn2",  1, 0, 2,  1, 0, 0,  7, 0, 0);
      applyStimulus("satUp3",  1, 1, 4,  1, 0, 0,  9, 1, 0);
      applyStimulus("ldPriC",  1, 1, 4,  1, 1, 12, 9, 0, 0);
      applyStimulus("ldPri4",  1, 1, 4,  1, 1, 4,  4, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("holdEn0", 0, 1, 5, 0, 0, 0, 4, 0, 0);
      end
      applyStimulus("step0Up", 1, 1, 0,  0, 0, 0,  4, 0, 0);
      applyStimulus("step0Dn", 1, 0, 0,  1, 0, 0,  4, 0, 0);
      applyStimulus("ld1b",    0, 1, 0,  0, 1, 1,  1, 0, 0);
      applyStimulus("satDnU1", 1, 0, 3,  1, 0, 0,  0, 0, 1);
      applyStimulus("satDnU2", 1, 0, 3,  1, 0, 0,  0, 0, 1);
      applyStimulus("ld7b",    0, 1, 0,  0, 1, 7,  7, 0, 0);
      applyStimulus("wrapUp9", 1, 1, 9,  0, 0, 0,  6, 1, 0);

      // Reset lands 3 ns after the edge that produced count 6 with ovf set.
      @(posedge clk);
      #3;
      reset = 1'b1;
      en    = 1'b0;
      load  = 1'b0;
      #1;
      checkOutput("asyncRst count",  32'(count), 0);
      checkOutput("asyncRst ovf",    32'(ovf),   0);
      checkOutput("asyncRst at_min", 32'(atMin), 1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstHeld count", 32'(count), 0);
      reset = 1'b0;
      applyStimulus("resume",  1, 1, 1,  0, 0, 0,  1, 0, 0);
      applyStimulus("idle",    0, 1, 1,  0, 0, 0,  1, 0, 0);

      @(negedge clk);
      enB   = 1'b1;
      stepB = 8'd10;
      itemB.tag = "w8Up10"; itemB.cnt = 4; itemB.ovf = 1'b1; itemB.unf = 1'b0;
      qB.push_back(itemB);
      @(negedge clk);
      enB = 1'b0;
      itemB.tag = "w8Hold"; itemB.cnt = 4; itemB.ovf = 1'b0; itemB.unf = 1'b0;
      qB.push_back(itemB);

      repeat (3) @(negedge clk);
      checkOutput("queueA drained", 32'(qA.size()), 0);
      checkOutput("queueB drained", 32'(qB.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter with programmable modulus, variable step, parallel load, count enable and selectable wrap/saturate mode. It is the next generation of the team's fixed 4-bit up/down counter. Typical uses are BCD/decade counting, position tracking and timeout generation inside larger control blocks. The count is fully registered, and over/underflow events are reported as single-cycle registered pulses.

## Interface
- `WIDTH`, 4: count, load value and step width in bits; minimum 2.
- `MAX_VAL`, 2**WIDTH-1: terminal count; the modulus is MAX_VAL+1; legal range 1..2**WIDTH-1.
- `RESET_VAL`, 0: count value on reset; must be ≤ MAX_VAL.

- `clk`  in  1  clock; rising edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable.
- `up_down`  in  1  direction: 1 = up, 0 = down.
- `step`  in  WIDTH  increment/decrement magnitude; values > MAX_VAL are clamped to MAX_VAL.
- `sat_mode`  in  1  0 = wrap modulo MAX_VAL+1; 1 = saturate at 0 / MAX_VAL.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  load data; values > MAX_VAL are clamped to MAX_VAL.
- `count`  out  WIDTH  registered count.
- `ovf`  out  1  registered one-cycle overflow pulse.
- `unf`  out  1  registered one-cycle underflow pulse.
- `at_max`  out  1  combinational: count == MAX_VAL.
- `at_min`  out  1  combinational: count == 0.

## Operation
- Reset values: count = RESET_VAL, ovf = 0, unf = 0. At reset, at_max and at_min follow RESET_VAL.
- Priority at each edge: reset > load > en > hold.
- Load: count ← min(load_val, MAX_VAL). ovf and unf are forced to 0. en, up_down and step are ignored.
- en = 0 and no load: count holds; ovf = unf = 0.
- Effective step s = min(step, MAX_VAL). If s = 0, count holds and no flags are raised.
- Up, when count + s > MAX_VAL:
  - wrap: count ← count + s − (MAX_VAL+1)
  - sat: count ← MAX_VAL
  - ovf = 1 for one cycle in both modes.
- Up, otherwise: count ← count + s.
- Down, when s > count:
  - wrap: count ← count + (MAX_VAL+1) − s
  - sat: count ← 0
  - unf = 1 for one cycle in both modes.
- Down, otherwise: count ← count − s.
- Saturated and still pushing (for example, count = MAX_VAL, up, s > 0): count stays put and ovf re-asserts every such cycle. The same applies to unf at 0.
- Arithmetic width: all intermediate sums use WIDTH+1 bits, so no intermediate wraps at 2**WIDTH.
- ovf and unf are never both 1 in the same cycle.
- count never leaves 0..MAX_VAL.
- Changing up_down or sat_mode between cycles takes effect on the next enabled edge. No pipeline flush is needed.

## Timing
- Latency: inputs sampled at edge N appear on count, ovf and unf after edge N. This is one cycle.
- ovf and unf are high for exactly the cycle following the edge that produced the event.
- Reset assertion is asynchronous: count, ovf and unf take their reset values immediately, mid-cycle. Reset deassertion is synchronous to clk. The first count change occurs on the first rising edge with reset low.
- at_max and at_min are decoded from the registered count. They change only with count, or with asynchronous reset.
- All inputs except reset are synchronous and must meet setup/hold to clk.

## Structure
- Shared package `updown_counter_pkg`:
  - constants `MODE_WRAP = 1'b0`, `MODE_SAT = 1'b1`, `DIR_UP = 1'b1`, `DIR_DOWN = 1'b0`;
  - a function computing the clamped value min(x, MAX_VAL).
- One combinational sub-module, `updown_counter_next`. It takes count, s, up_down and sat_mode, and returns next_count, ovf_next and unf_next.
- The top level holds the count/flag registers, the load/enable priority mux, the clamps and the at_max/at_min decode.
- A compile-time check flags RESET_VAL > MAX_VAL and MAX_VAL > 2**WIDTH−1.

## Test plan
All scenarios use WIDTH = 4, MAX_VAL = 9 and RESET_VAL = 0 (decade counter) unless stated.
- Wrap up: count = 8, en = 1, up, step = 1, sat_mode = 0 → 9 (at_max = 1), then 0 with ovf = 1 for one cycle, then 1 with ovf = 0.
- Wrap down with step: count = 1, down, step = 3 → count = 8, unf = 1 for one cycle. Then step = 12 (clamped to 9) from 8 → count = 9, unf = 1.
- Saturate: count = 7, up, step = 4, sat_mode = 1 → count = 9, ovf = 1. The next enabled edge → count = 9, ovf = 1 again. Switch to down, step = 2 → count = 7, ovf = 0.
- Load priority: load = 1, en = 1, up, load_val = 12 → count = 9 (clamped), ovf = 0. Then load_val = 4 → count = 4.
- Hold cases: en = 0 for 3 edges → count unchanged, flags 0. en = 1 with step = 0 → count unchanged, flags 0.
- Asynchronous reset mid-operation: count = 6, with ovf pending from the previous edge. Assert reset 3 ns after an edge → count = 0, ovf = 0 immediately. Deassert → counting resumes from 0 on the next edge.
- Parameter sweep: WIDTH = 8, MAX_VAL = 255, RESET_VAL = 250, up step 10 → 250 → 4, with ovf = 1.
